mode7_span_stepper: RTL and testbench

Parametrised per-scanline texture-coordinate generator for the Mode-7 floor renderer. It sits between the per-frame frustum setup and the map/texture ROM lookups. For each ground scanline it interpolates the left and right span endpoints from four frame corners using a per-line perspective scale. It then streams one (u,v) texel coordinate per pixel over a valid/ready handshake, with selectable wrap, clamp or border addressing.

---
 rtl/mode7_span_stepper.sv | 232 +++++++++++++++++++++++
 tb/tb_mode7_span_stepper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode7_span_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : mode7_span_stepper
//  Purpose  : Per-scanline Mode-7 span interpolation and per-pixel (u,v)
//             texel coordinate streamer with wrap/clamp/border addressing.
//  Revision : 1.0  initial release
// ============================================================================
module mode7_span_stepper #(
    parameter int COORD_W      = 29,
    parameter int FRAC_W       = 16,
    parameter int MAP_INT_W    = 9,
    parameter int SCALE_W      = 17,
    parameter int H_ACTIVE     = 640,
    parameter int STRIDE_MUL   = 102,
    parameter int STRIDE_SHIFT = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              frame_start,
    input  logic signed [COORD_W-1:0]         a_u,
    input  logic signed [COORD_W-1:0]         a_v,
    input  logic signed [COORD_W-1:0]         b_u,
    input  logic signed [COORD_W-1:0]         b_v,
    input  logic signed [COORD_W-1:0]         c_u,
    input  logic signed [COORD_W-1:0]         c_v,
    input  logic signed [COORD_W-1:0]         d_u,
    input  logic signed [COORD_W-1:0]         d_v,
    input  logic                              line_start,
    input  logic [SCALE_W-1:0]                line_scale,
    input  logic [1:0]                        wrap_mode,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAP_INT_W+FRAC_W-1:0]       out_u,
    output logic [MAP_INT_W+FRAC_W-1:0]       out_v,
    output logic [9:0]                        out_x,
    output logic                              out_last,
    output logic                              out_oob,
    output logic                              line_overrun
);

    localparam int         c_M           = MAP_INT_W + FRAC_W;
    localparam int         c_MUL_B_W     = 32;
    localparam int         c_PROD_W      = COORD_W + 1 + c_MUL_B_W;
    localparam logic [9:0] c_X_LAST      = 10'(H_ACTIVE - 1);
    localparam logic [2:0] c_K_LOAD      = 3'd6;
    localparam logic [1:0] c_MODE_CLAMP  = 2'd1;
    localparam logic [1:0] c_MODE_BORDER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [2:0]                r_k;
    logic [SCALE_W-1:0]        r_scale;
    logic [1:0]                r_mode;
    logic signed [COORD_W-1:0] r_shadow [8];
    logic signed [COORD_W-1:0] r_active [8];
    logic signed [COORD_W-1:0] r_left_u, r_left_v, r_right_u, r_right_v;
    logic signed [COORD_W-1:0] r_u_stride, r_v_stride, r_u, r_v;

    logic signed [COORD_W-1:0] w_corner_in [8];
    logic signed [COORD_W:0]   w_mul_a;
    logic signed [c_MUL_B_W-1:0] w_mul_b;
    logic signed [c_PROD_W-1:0]  w_prod;
    logic signed [COORD_W-1:0] w_base, w_result;
    logic                      w_is_stride;
    logic signed [COORD_W-1:0] w_next_u, w_next_v;
    logic [c_M:0]              w_addr_u, w_addr_v;

    function automatic logic signed [COORD_W:0] widen(input logic signed [COORD_W-1:0] val);
        return {val[COORD_W-1], val};
    endfunction

    // Returns {oob, addressed coordinate}; the accumulator itself is never modified.
    function automatic logic [c_M:0] address(input logic signed [COORD_W-1:0] acc,
                                             input logic [1:0] mode);
        logic         below;
        logic         above;
        logic [c_M-1:0] val;
        below = acc[COORD_W-1];
        above = !below && (acc[COORD_W-2:c_M] != '0);
        val   = acc[c_M-1:0];
        if (mode == c_MODE_CLAMP) begin
            if (below) begin
                val = '0;
            end else if (above) begin
                val = '1;
            end
        end
        return {(mode == c_MODE_BORDER) && (below || above), val};
    endfunction

    assign w_corner_in[0] = a_u;
    assign w_corner_in[1] = a_v;
    assign w_corner_in[2] = b_u;
    assign w_corner_in[3] = b_v;
    assign w_corner_in[4] = c_u;
    assign w_corner_in[5] = c_v;
    assign w_corner_in[6] = d_u;
    assign w_corner_in[7] = d_v;

    // Shared multiplier: k0..3 interpolate far/near corners, k4..5 derive strides.
    always_comb begin
        w_mul_a     = '0;
        w_mul_b     = '0;
        w_base      = '0;
        w_is_stride = 1'b0;
        if (!r_k[2]) begin
            w_mul_a = widen(r_active[{1'b0, r_k[1:0]}]) - widen(r_active[{1'b1, r_k[1:0]}]);
            w_mul_b = {{(c_MUL_B_W-SCALE_W){1'b0}}, r_scale};
            w_base  = r_active[{1'b1, r_k[1:0]}];
        end else begin
            w_mul_a     = r_k[0] ? (widen(r_right_v) - widen(r_left_v))
                                 : (widen(r_right_u) - widen(r_left_u));
            w_mul_b     = c_MUL_B_W'(STRIDE_MUL);
            w_is_stride = 1'b1;
        end
    end

    assign w_prod   = c_PROD_W'(w_mul_a) * c_PROD_W'(w_mul_b);
    assign w_result = w_is_stride ? COORD_W'(w_prod >>> STRIDE_SHIFT)
                                  : w_base + COORD_W'(w_prod >>> FRAC_W);

    assign w_next_u = (r_state == S_RUN) ? r_u + r_u_stride : r_left_u;
    assign w_next_v = (r_state == S_RUN) ? r_v + r_v_stride : r_left_v;
    assign w_addr_u = address(w_next_u, r_mode);
    assign w_addr_v = address(w_next_v, r_mode);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_scale      <= '0;
            r_mode       <= '0;
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_left_u     <= '0;
            r_left_v     <= '0;
            r_right_u    <= '0;
            r_right_v    <= '0;
            r_u_stride   <= '0;
            r_v_stride   <= '0;
            r_u          <= '0;
            r_v          <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_u        <= '0;
            out_v        <= '0;
            out_x        <= '0;
            out_last     <= 1'b0;
            out_oob      <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            line_overrun <= line_start && (r_state != S_IDLE);
            if (frame_start) begin
                for (int i = 0; i < 8; i++) begin
                    r_shadow[i] <= w_corner_in[i];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (line_start) begin
                        r_state <= S_CALC;
                        r_k     <= '0;
                        r_scale <= line_scale;
                        r_mode  <= wrap_mode;
                        busy    <= 1'b1;
                        // Same-cycle frame_start is forwarded into the active bank.
                        for (int i = 0; i < 8; i++) begin
                            r_active[i] <= frame_start ? w_corner_in[i] : r_shadow[i];
                        end
                    end
                end
                S_CALC: begin
                    case (r_k)
                        3'd0:    r_left_u   <= w_result;
                        3'd1:    r_left_v   <= w_result;
                        3'd2:    r_right_u  <= w_result;
                        3'd3:    r_right_v  <= w_result;
                        3'd4:    r_u_stride <= w_result;
                        3'd5:    r_v_stride <= w_result;
                        default: ;
                    endcase
                    if (r_k == c_K_LOAD) begin
                        r_state   <= S_RUN;
                        r_u       <= r_left_u;
                        r_v       <= r_left_v;
                        out_valid <= 1'b1;
                        out_x     <= '0;
                        out_u     <= w_addr_u[c_M-1:0];
                        out_v     <= w_addr_v[c_M-1:0];
                        out_oob   <= w_addr_u[c_M] | w_addr_v[c_M];
                        out_last  <= (c_X_LAST == 10'd0);
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (out_x == c_X_LAST) begin
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_u     <= '0;
                            out_v     <= '0;
                            out_x     <= '0;
                            out_oob   <= 1'b0;
                        end else begin
                            r_u      <= w_next_u;
                            r_v      <= w_next_v;
                            out_x    <= out_x + 10'd1;
                            out_last <= ((out_x + 10'd1) == c_X_LAST);
                            out_u    <= w_addr_u[c_M-1:0];
                            out_v    <= w_addr_v[c_M-1:0];
                            out_oob  <= w_addr_u[c_M] | w_addr_v[c_M];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mode7_span_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mode7_span_stepper
//  Purpose  : Self-checking bench for mode7_span_stepper against a closed-form
//             per-pixel reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mode7_span_stepper;

    localparam int     COORD_W      = 29;
    localparam int     FRAC_W       = 16;
    localparam int     MAP_INT_W    = 9;
    localparam int     SCALE_W      = 17;
    localparam int     H_ACTIVE     = 640;
    localparam int     STRIDE_MUL   = 102;
    localparam int     STRIDE_SHIFT = 16;
    localparam int     M            = MAP_INT_W + FRAC_W;
    localparam longint LIM          = longint'(1) << M;

    logic                      clk         = 1'b0;
    logic                      resetn      = 1'b0;
    logic                      frame_start = 1'b0;
    logic                      line_start  = 1'b0;
    logic                      out_ready   = 1'b0;
    logic signed [COORD_W-1:0] cdrv [8];
    logic [SCALE_W-1:0]        line_scale  = '0;
    logic [1:0]                wrap_mode   = '0;
    logic                      busy, out_valid, out_last, out_oob, line_overrun;
    logic [M-1:0]              out_u, out_v;
    logic [9:0]                out_x;

    longint newc     [8];
    longint shadow_m [8];
    longint active_m [8];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    mode7_span_stepper dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .a_u          (cdrv[0]),
        .a_v          (cdrv[1]),
        .b_u          (cdrv[2]),
        .b_v          (cdrv[3]),
        .c_u          (cdrv[4]),
        .c_v          (cdrv[5]),
        .d_u          (cdrv[6]),
        .d_v          (cdrv[7]),
        .line_start   (line_start),
        .line_scale   (line_scale),
        .wrap_mode    (wrap_mode),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_u        (out_u),
        .out_v        (out_v),
        .out_x        (out_x),
        .out_last     (out_last),
        .out_oob      (out_oob),
        .line_overrun (line_overrun)
    );

    function automatic longint wrapc(input longint val);
        longint t;
        t = val & ((longint'(1) << COORD_W) - 1);
        if (t >= (longint'(1) << (COORD_W - 1))) t -= longint'(1) << COORD_W;
        return t;
    endfunction

    function automatic longint lerp(input longint near, input longint far, input longint sc);
        return wrapc(near + (((far - near) * sc) >>> FRAC_W));
    endfunction

    function automatic longint stride(input longint l, input longint r);
        return wrapc(((r - l) * STRIDE_MUL) >>> STRIDE_SHIFT);
    endfunction

    function automatic void addr(input longint acc, input int md, output longint val, output bit oob);
        oob = (md == 2) && (acc < 0 || acc >= LIM);
        if (md == 1) val = (acc < 0) ? 0 : ((acc >= LIM) ? LIM - 1 : acc);
        else         val = acc & (LIM - 1);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_new();
        for (int i = 0; i < 8; i++) begin
            cdrv[i]     = COORD_W'(newc[i]);
            shadow_m[i] = newc[i];
        end
    endtask

    task automatic load_corners();
        drive_new();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic rand_corners(input bit full);
        for (int i = 0; i < 8; i++) begin
            if (full) newc[i] = wrapc(longint'($urandom));
            else      newc[i] = longint'($urandom_range(0, 1 << 27)) - (longint'(1) << 26);
        end
    endtask

    // ev_kind: 1 frame_start mid-line, 2 line_start while busy, 3 reset, 4 five-cycle stall
    task automatic run_line(input int sc, input int md, input bit rnd_ready,
                            input int ev_x, input int ev_kind, input bit fs_too);
        longint lu, lv, ru, rv, su, sv, eu, exp_v, acc;
        bit     ou, ov, fired, hs;
        int     n, x, cyc, stall, ovs;
        line_scale = SCALE_W'(sc);
        wrap_mode  = 2'(md);
        line_start = 1'b1;
        if (fs_too) begin
            frame_start = 1'b1;
            drive_new();
        end
        for (int i = 0; i < 8; i++) active_m[i] = shadow_m[i];
        lu = lerp(active_m[4], active_m[0], sc);
        lv = lerp(active_m[5], active_m[1], sc);
        ru = lerp(active_m[6], active_m[2], sc);
        rv = lerp(active_m[7], active_m[3], sc);
        su = stride(lu, ru);
        sv = stride(lv, rv);
        @(posedge clk); #1;
        line_start  = 1'b0;
        frame_start = 1'b0;
        check("busy_after_accept", longint'(busy), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_latency", n, 7);
        if (!out_valid) return;
        x = 0; cyc = 0; stall = 0; ovs = 0; fired = 1'b0;
        while (x < H_ACTIVE && cyc < 8 * H_ACTIVE) begin
            line_start  = 1'b0;
            frame_start = 1'b0;
            if (ovs == 1) begin
                check("overrun_pulse", longint'(line_overrun), 1);
                ovs = 2;
            end else if (ovs == 2) begin
                check("overrun_single", longint'(line_overrun), 0);
                ovs = 0;
            end
            acc = wrapc(lu + x * su);
            addr(acc, md, eu, ou);
            acc = wrapc(lv + x * sv);
            addr(acc, md, exp_v, ov);
            check("valid", longint'(out_valid), 1);
            check("busy", longint'(busy), 1);
            check("out_x", longint'(out_x), x);
            check("out_u", longint'(out_u), eu);
            check("out_v", longint'(out_v), exp_v);
            check("out_last", longint'(out_last), longint'(x == H_ACTIVE - 1));
            check("out_oob", longint'(out_oob), longint'(ou | ov));
            if (!fired && x == ev_x) begin
                fired = 1'b1;
                case (ev_kind)
                    1: begin
                        rand_corners(1'b0);
                        frame_start = 1'b1;
                        drive_new();
                    end
                    2: begin
                        line_start = 1'b1;
                        line_scale = SCALE_W'($urandom);
                        wrap_mode  = 2'($urandom);
                        ovs        = 1;
                    end
                    3: begin
                        resetn = 1'b0;
                        #1;
                        check("rst_valid", longint'(out_valid), 0);
                        check("rst_busy", longint'(busy), 0);
                        check("rst_u", longint'(out_u), 0);
                        check("rst_v", longint'(out_v), 0);
                        check("rst_x", longint'(out_x), 0);
                        check("rst_last", longint'(out_last), 0);
                        check("rst_oob", longint'(out_oob), 0);
                        for (int i = 0; i < 8; i++) begin
                            shadow_m[i] = 0;
                            active_m[i] = 0;
                        end
                        out_ready = 1'b0;
                        repeat (2) @(posedge clk);
                        #1;
                        resetn = 1'b1;
                        return;
                    end
                    4: stall = 5;
                    default: ;
                endcase
            end
            if (stall > 0) begin
                hs = 1'b0;
                stall--;
            end else begin
                hs = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            out_ready = hs;
            @(posedge clk); #1;
            cyc++;
            if (hs) x++;
        end
        line_start  = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        check("line_complete", x, H_ACTIVE);
        check("valid_drop", longint'(out_valid), 0);
        check("busy_drop", longint'(busy), 0);
        check("last_drop", longint'(out_last), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            cdrv[i]     = '0;
            newc[i]     = 0;
            shadow_m[i] = 0;
            active_m[i] = 0;
        end
        #12;
        check("reset_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_u", longint'(out_u), 0);
        check("reset_x", longint'(out_x), 0);
        check("reset_overrun", longint'(line_overrun), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Flat corners, zero scale.
        for (int i = 0; i < 8; i++) newc[i] = 'h10000;
        load_corners();
        run_line(0, 0, 1'b0, -1, 0, 1'b0);

        // Linear ramp: u stride 6528.
        newc = '{0, 0, 64 << 16, 0, 0, 0, 64 << 16, 0};
        load_corners();
        run_line(int'($urandom_range(0, 65536)), 0, 1'b0, -1, 0, 1'b0);

        // Half scale towards far-left, with a five-cycle stall at x=10.
        newc = '{'h200000, 0, 0, 0, 0, 0, 0, 0};
        load_corners();
        run_line('h8000, 0, 1'b0, 10, 4, 1'b0);

        // Negative coordinate in every addressing mode.
        for (int i = 0; i < 8; i++) newc[i] = -'h10000;
        load_corners();
        for (int md = 0; md < 3; md++) run_line(0, md, 1'b0, -1, 0, 1'b0);

        // Random corners, modes and back-pressure.
        for (int r = 0; r < 4; r++) begin
            rand_corners(r[0]);
            load_corners();
            run_line(int'($urandom_range(0, 65536)), int'($urandom_range(0, 3)), 1'b1, -1, 0, 1'b0);
        end

        // frame_start mid-line, then a line on the new corners.
        rand_corners(1'b0);
        load_corners();
        run_line(int'($urandom_range(0, 65536)), 2, 1'b1, 100, 1, 1'b0);
        run_line(int'($urandom_range(0, 65536)), 0, 1'b1, -1, 0, 1'b0);

        // line_start while busy.
        rand_corners(1'b0);
        load_corners();
        run_line(int'($urandom_range(0, 65536)), 1, 1'b1, 200, 2, 1'b0);

        // Reset mid-line, then a normal line.
        run_line(int'($urandom_range(0, 65536)), 0, 1'b1, 300, 3, 1'b0);
        @(posedge clk); #1;
        rand_corners(1'b0);
        load_corners();
        run_line(int'($urandom_range(0, 65536)), 2, 1'b1, -1, 0, 1'b0);

        // Simultaneous frame_start and line_start.
        rand_corners(1'b0);
        run_line(int'($urandom_range(0, 65536)), 0, 1'b1, -1, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
